// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : game_flow_ctrl
//  Purpose  : Top-level game flow controller. Runs the screen state machine
//             (START / PLAY / PAUSE / OVER), the start-screen level selector
//             with its on-screen indicator boxes, and picks the registered
//             final pixel colour for the VGA path.
//  Config   : GAME_PAUSE_EN - when defined, compiles in the PAUSE state,
//             the dimmed playfield colour and the 'paused' output. When
//             undefined, select is ignored in PLAY and 'paused' is 0.
//  Ports    : clk, reset (sync, active-high)
//             select_db/down_db/up_db - debounced single-cycle button pulses
//             game_over               - playfield overflow level
//             frame_tick              - one pulse per video frame
//             x, y                    - current pixel coordinates
//             colour_start/play/over  - renderer colours (RGB 4:4:4)
//             colour_out              - registered final pixel colour
//             level                   - selected level, 0-based
//             start_en/play_en/over_en- renderer enables
//             paused                  - high in PAUSE
//  Revision : 1.0 - initial release
// ============================================================================
module game_flow_ctrl #(
   parameter int NUM_LEVELS = 3,
   parameter int LEVEL_W    = 3,
   parameter int BOX_X0     = 223,
   parameter int BOX_Y0     = 273,
   parameter int BOX_SIZE   = 8,
   parameter int BOX_PITCH  = 16,
   parameter int OVER_TICKS = 600
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               select_db,
   input  logic               down_db,
   input  logic               up_db,
   input  logic               game_over,
   input  logic               frame_tick,
   input  logic [9:0]         x,
   input  logic [9:0]         y,
   input  logic [11:0]        colour_start,
   input  logic [11:0]        colour_play,
   input  logic [11:0]        colour_over,
   output logic [11:0]        colour_out,
   output logic [LEVEL_W-1:0] level,
   output logic               start_en,
   output logic               play_en,
   output logic               over_en,
   output logic               paused
);

`ifdef GAME_PAUSE_EN
   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_PLAY  = 2'd1,
      ST_PAUSE = 2'd2,
      ST_OVER  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_PLAY  = 2'd1,
      ST_OVER  = 2'd3
   } state_t;
`endif

   localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(NUM_LEVELS - 1);
   // Only meaningful when OVER_TICKS != 0; the auto-return term is gated.
   localparam logic [15:0]        OVER_LAST = 16'(OVER_TICKS - 1);
   localparam logic [10:0]        BOX_Y_LO  = 11'(BOX_Y0);
   localparam logic [10:0]        BOX_Y_HI  = 11'(BOX_Y0 + BOX_SIZE - 1);

   state_t               state_q, state_d;
   logic [LEVEL_W-1:0]   level_q, level_d;
   logic [15:0]          timer_q, timer_d;
   logic [11:0]          colour_out_q, colour_out_d;

   logic                 auto_ret;
   logic                 box_hit;
   logic                 box_sel;
   logic [10:0]          x_ext;
   logic [10:0]          y_ext;

   // Left edge of indicator box i, widened so large parameters cannot wrap.
   function automatic logic [10:0] box_left(input int i);
      return 11'(BOX_X0 + i * BOX_PITCH);
   endfunction

   assign x_ext = {1'b0, x};
   assign y_ext = {1'b0, y};

   assign auto_ret = (OVER_TICKS != 0) && frame_tick && (timer_q == OVER_LAST);

   // ------------------------------------------------------------------
   // Next state, level selector and over timer
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      timer_d = '0;

      case (state_q)
         ST_START: begin
            if (select_db) begin
               state_d = ST_PLAY;
            end
            if (down_db && !up_db) begin
               level_d = (level_q == LVL_MAX) ? '0 : level_q + 1'b1;
            end else if (up_db && !down_db) begin
               level_d = (level_q == '0) ? LVL_MAX : level_q - 1'b1;
            end
         end
         ST_PLAY: begin
            // game_over wins over a simultaneous select
            if (game_over) begin
               state_d = ST_OVER;
`ifdef GAME_PAUSE_EN
            end else if (select_db) begin
               state_d = ST_PAUSE;
`endif
            end
         end
`ifdef GAME_PAUSE_EN
         ST_PAUSE: begin
            if (select_db) begin
               state_d = ST_PLAY;
            end
         end
`endif
         ST_OVER: begin
            // Timer is zero outside OVER, so every entry starts from 0.
            timer_d = frame_tick ? timer_q + 16'd1 : timer_q;
            if (select_db || auto_ret) begin
               state_d = ST_START;
            end
         end
         default: begin
            state_d = ST_START;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Indicator box hit test (only used in START)
   // ------------------------------------------------------------------
   always_comb begin
      box_hit = 1'b0;
      box_sel = 1'b0;
      if ((y_ext >= BOX_Y_LO) && (y_ext <= BOX_Y_HI)) begin
         for (int i = 0; i < NUM_LEVELS; i++) begin
            if ((x_ext >= box_left(i)) &&
                (x_ext <= box_left(i) + 11'(BOX_SIZE - 1))) begin
               box_hit = 1'b1;
               if (level_q == LEVEL_W'(i)) begin
                  box_sel = 1'b1;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Colour select, using the current state and level
   // ------------------------------------------------------------------
   always_comb begin
      colour_out_d = 12'h000;
      case (state_q)
         ST_START: begin
            if (box_hit) begin
               colour_out_d = box_sel ? 12'hFFF : 12'h000;
            end else begin
               colour_out_d = colour_start;
            end
         end
         ST_PLAY: begin
            colour_out_d = colour_play;
         end
`ifdef GAME_PAUSE_EN
         ST_PAUSE: begin
            // Halve each 4-bit channel to dim the frozen playfield
            colour_out_d = {1'b0, colour_play[11:9],
                            1'b0, colour_play[7:5],
                            1'b0, colour_play[3:1]};
         end
`endif
         ST_OVER: begin
            colour_out_d = colour_over;
         end
         default: begin
            colour_out_d = 12'h000;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_START;
         level_q      <= '0;
         timer_q      <= '0;
         colour_out_q <= 12'h000;
      end else begin
         state_q      <= state_d;
         level_q      <= level_d;
         timer_q      <= timer_d;
         colour_out_q <= colour_out_d;
      end
   end

   assign colour_out = colour_out_q;
   assign level      = level_q;
   assign start_en   = (state_q == ST_START);
   assign play_en    = (state_q == ST_PLAY);
   assign over_en    = (state_q == ST_OVER);
`ifdef GAME_PAUSE_EN
   assign paused     = (state_q == ST_PAUSE);
`else
   assign paused     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game flow controller: the screen state machine (start, play, pause, over) plus the start-screen level selector and its on-screen indicator boxes, generalised to `NUM_LEVELS` levels. It sits between the debounced button pulses and the three screen renderers (start bitmap, playfield, game-over bitmap). It produces per-screen enables, the selected level and the registered final pixel colour for the VGA path.

## Interface
- `NUM_LEVELS`, 3: number of selectable levels, 2..8.
- `LEVEL_W`, 3: width of `level`; must satisfy 2^LEVEL_W >= NUM_LEVELS.
- `BOX_X0`, 223: left x of indicator box 0.
- `BOX_Y0`, 273: top y of all indicator boxes.
- `BOX_SIZE`, 8: box edge length in pixels.
- `BOX_PITCH`, 16: x distance between left edges of consecutive boxes (> BOX_SIZE).
- `OVER_TICKS`, 600: frame ticks before the over screen auto-returns to start; 0 disables auto-return.

Ports:
- `clk` in 1: system/pixel clock.
- `reset` in 1: synchronous, active-high.
- `select_db` in 1: debounced select, single-cycle pulse.
- `down_db` in 1: debounced down, single-cycle pulse.
- `up_db` in 1: debounced up, single-cycle pulse.
- `game_over` in 1: level from playfield, high when stack overflows.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `x`, `y` in 10 each: current pixel coordinates.
- `colour_start`, `colour_play`, `colour_over` in 12 each: renderer outputs, RGB 4:4:4.
- `colour_out` out 12: registered final pixel colour.
- `level` out LEVEL_W: selected level, 0-based.
- `start_en`, `play_en`, `over_en` out 1 each: renderer enables.
- `paused` out 1: high in PAUSE.

## Operation
- States: START, PLAY, PAUSE, OVER. Transitions are evaluated each `clk` edge:
  - START→PLAY on `select_db`.
  - PLAY→OVER on `game_over`; `game_over` has priority over `select_db`.
  - PLAY→PAUSE on `select_db`.
  - PAUSE→PLAY on `select_db`. `game_over` is ignored in PAUSE.
  - OVER→START on `select_db`, or on auto-return.
- Level selector is active only in START.
  - `down_db` alone: `level` = `level`+1, wrapping NUM_LEVELS-1→0.
  - `up_db` alone: `level` = `level`-1, wrapping 0→NUM_LEVELS-1.
  - Both pulses in the same cycle: no change.
  - Outside START, `level` holds.
  - `level` is retained across OVER→START.
- Over timer (16-bit):
  - Cleared on every entry to OVER.
  - Increments on `frame_tick` while in OVER.
  - When `frame_tick` is high and the count is OVER_TICKS-1, the next state is START.
  - OVER_TICKS=0 disables the timer.
  - `select_db` in the same cycle gives the same result (START).
- Enables are decoded combinationally from the state register:
  - `start_en`=START.
  - `play_en`=PLAY.
  - `over_en`=OVER.
  - `paused`=PAUSE.
  - `play_en` is low in PAUSE, which freezes the playfield.
- Colour selection, before the output register:
  - In START, box i covers x in [BOX_X0+i·BOX_PITCH, +BOX_SIZE-1] and y in [BOX_Y0, BOX_Y0+BOX_SIZE-1].
  - A pixel in box i is white (12'hFFF) if i==`level`, else black.
  - START pixels outside all boxes use `colour_start`.
  - PLAY uses `colour_play`.
  - PAUSE uses `colour_play` with each 4-bit channel shifted right by 1 (dimmed).
  - OVER uses `colour_over`.
- Reset values:
  - State START.
  - `level` 0.
  - Timer 0.
  - `colour_out` 0.
  - Hence `start_en`=1 and all other enables 0.

## Timing
- A state or level change is visible on the enables and `level` one cycle after the input pulse.
- `colour_out` has 1-cycle latency: the value for (`x`,`y`) at cycle n appears at cycle n+1.
- The cycle-n colour uses the cycle-n state and `level`.
- Reset asserted mid-game: on the next edge all registers take their reset values, and the timer is not preserved.
- Inputs are sampled only on `clk` edges. A pulse longer than one cycle is treated as repeated pulses; the debouncers guarantee single-cycle pulses.

## Configuration
- `GAME_PAUSE_EN` defined: the PAUSE state, the dimming and the `paused` output are compiled in, as described above.
- `GAME_PAUSE_EN` undefined: there is no PAUSE state, `select_db` is ignored in PLAY, and `paused` is tied to 0.

## Test plan
- Reset then `select_db` → `play_en`=1 the next cycle, `level`=0, and `colour_out` tracks `colour_play` delayed by 1 cycle.
- In START with NUM_LEVELS=3, pulse `down_db` 3 times → `level` goes 1,2,0. Then `up_db` → 2. Then `up_db`+`down_db` together → stays 2. Pixel (BOX_X0+2·BOX_PITCH, BOX_Y0) → 12'hFFF; box 0 pixel → 12'h000.
- In PLAY, `game_over`=1 and `select_db` in the same cycle → OVER, not PAUSE.
- With GAME_PAUSE_EN: in PLAY, `select_db` → `paused`=1 and `play_en`=0. `colour_play`=12'hF84 → `colour_out`=12'h742. `game_over`=1 is then ignored. `select_db` → PLAY.
- OVER_TICKS=4: enter OVER and give 3 `frame_tick` pulses → still OVER; the 4th → START, with `level` unchanged.
- Assert `reset` for 1 cycle while in OVER with timer=2 → START, `level`=0, `colour_out`=0 the next cycle.
